// File: rtl/trng_word_arbiter.sv
// Filters TRNG words (warm-up discard, repetition-count health test), buffers them,
// and hands each buffered word to exactly one requester in round-robin order.
module trng_word_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DEPTH     = 4,
  parameter int WARMUP    = 16,
  parameter int REP_LIMIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [31:0]              trng_data,
  input  logic                     trng_valid,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [31:0]              rnd_data,
  output logic                     rnd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     health_fail,
  output logic                     warm
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int IW  = $clog2(N_REQ);
  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  localparam logic [RCW-1:0] REP_MAX   = RCW'(REP_LIMIT);
  localparam logic [LW-1:0]  FULL_LVL  = LW'(DEPTH);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t           state, state_next;
  logic [WCW-1:0]   warm_cnt;
  logic [RCW-1:0]   rep_cnt, rep_next;
  logic [31:0]      prev_word;
  logic             take, trip;

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             full, push, pop;

  // rr_ptr is the index searched first, i.e. last winner + 1 (mod N_REQ).
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win_idx;
  logic             win_found;

  always_comb begin
    state_next = state;
    rep_next   = rep_cnt;
    take       = 1'b0;
    trip       = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (trng_valid && warm_cnt == WARM_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trng_valid) begin
          take = 1'b1;
          if (rep_cnt == '0 || trng_data != prev_word) begin
            rep_next = RCW'(1);
          end else begin
            rep_next = rep_cnt + RCW'(1);
          end
          if (rep_next == REP_MAX) begin
            trip       = 1'b1;
            state_next = ST_FAIL;
          end
        end
      end
      default: state_next = ST_FAIL;
    endcase
  end

  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign full = (count == FULL_LVL);
  assign pop  = (state == ST_RUN) && !trip && (count != '0) && win_found;
  assign push = take && !trip && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= RESET_STATE;
      warm_cnt  <= '0;
      warm      <= (WARMUP == 0);
      rep_cnt   <= '0;
      prev_word <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WARMUP && trng_valid) begin
        warm_cnt <= warm_cnt + WCW'(1);
      end
      if (state == ST_WARMUP && state_next == ST_RUN) begin
        warm <= 1'b1;
      end
      // Dropped (FIFO-full) words still feed the health test.
      if (take) begin
        rep_cnt   <= rep_next;
        prev_word <= trng_data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= trng_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst || trip || state == ST_FAIL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      rnd_valid <= pop;
      gnt       <= pop ? (N_REQ'(1) << win_idx) : '0;
      if (pop) begin
        rnd_data <= mem[rd_ptr];
        rr_ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
      end
    end
  end

  assign fifo_level  = count;
  assign health_fail = (state == ST_FAIL);

endmodule
